// File: rtl/onewire_read_byte.sv
// onewire_read_byte
// Reads one byte from a 1-Wire bus as eight master-initiated read slots,
// LSB first. Each slot drives the bus low for T_LOW_US, releases it, samples
// the synchronized bus level T_SAMPLE_US later, then waits out the remainder
// of the T_SLOT_US slot.
//
// Optional feature: define ONEWIRE_READ_CRC8_EN to accumulate a Dallas CRC-8
// (polynomial x^8+x^5+x^4+1, reflected constant 8'h8C) over every sampled bit.
// Without it crc_out is tied to zero and crc_clr is unused.
//
// Ports:
//   clk        system clock (CLK_FREQ Hz)
//   rst        asynchronous, active-high reset
//   start      request a byte read; only honoured while idle
//   dq_in      raw 1-Wire bus level (asynchronous)
//   crc_clr    clears the CRC accumulator (wins over a same-cycle bit update)
//   dq_out_en  1 = pull the bus low, 0 = release
//   busy       byte read in progress
//   done       one-cycle pulse when the byte is complete
//   data_out   received byte; holds until the next byte shifts in
//   crc_out    running CRC-8 (8'h00 when the CRC feature is not built)
module onewire_read_byte #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int T_LOW_US    = 6,
    parameter int T_SAMPLE_US = 9,
    parameter int T_SLOT_US   = 70
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       dq_in,
    input  logic       crc_clr,
    output logic       dq_out_en,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_out,
    output logic [7:0] crc_out
);

    localparam int CYC        = CLK_FREQ / 1_000_000;
    localparam int LOW_CYC    = T_LOW_US * CYC;
    localparam int SAMPLE_CYC = T_SAMPLE_US * CYC;
    localparam int REC_CYC    = (T_SLOT_US - T_LOW_US - T_SAMPLE_US) * CYC;
    localparam int MAX_A      = (LOW_CYC > SAMPLE_CYC) ? LOW_CYC : SAMPLE_CYC;
    localparam int MAX_CYC    = (MAX_A > REC_CYC) ? MAX_A : REC_CYC;
    localparam int CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] LOW_LAST    = CNT_W'(LOW_CYC - 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0] REC_LAST    = CNT_W'(REC_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        WAIT_SAMPLE,
        RECOVER
    } state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [2:0]       bit_cnt, next_bit_cnt;
    logic             next_done;
    logic             sample_bit;
    logic             dq_sync1, dq_sync2;

    // Two-flop synchronizer; resets to the idle (pulled-up) bus level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dq_sync1 <= 1'b1;
            dq_sync2 <= 1'b1;
        end else begin
            dq_sync1 <= dq_in;
            dq_sync2 <= dq_sync1;
        end
    end

    // State, counters and the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            done    <= 1'b0;
        end else begin
            state   <= next_state;
            cnt     <= next_cnt;
            bit_cnt <= next_bit_cnt;
            done    <= next_done;
        end
    end

    // One shared cycle counter times every phase; it restarts at each phase
    // boundary so each phase compares against its own last-cycle value.
    always_comb begin
        next_state   = state;
        next_cnt     = cnt + 1'b1;
        next_bit_cnt = bit_cnt;
        next_done    = 1'b0;
        sample_bit   = 1'b0;
        case (state)
            IDLE: begin
                next_cnt = '0;
                if (start) begin
                    next_state   = LOW;
                    next_bit_cnt = '0;
                end
            end
            LOW: begin
                if (cnt == LOW_LAST) begin
                    next_state = WAIT_SAMPLE;
                    next_cnt   = '0;
                end
            end
            WAIT_SAMPLE: begin
                if (cnt == SAMPLE_LAST) begin
                    sample_bit = 1'b1;
                    next_state = RECOVER;
                    next_cnt   = '0;
                end
            end
            RECOVER: begin
                if (cnt == REC_LAST) begin
                    next_cnt = '0;
                    if (bit_cnt == 3'd7) begin
                        next_state = IDLE;
                        next_done  = 1'b1;
                    end else begin
                        next_bit_cnt = bit_cnt + 3'd1;
                        next_state   = LOW;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Decoded from state so an asynchronous reset releases the bus at once.
    assign dq_out_en = (state == LOW);
    assign busy      = (state != IDLE);

    // Bits arrive LSB first: shift right, new bit enters at the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= 8'h00;
        end else if (sample_bit) begin
            data_out <= {dq_sync2, data_out[7:1]};
        end
    end

`ifdef ONEWIRE_READ_CRC8_EN
    logic [7:0] crc;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic       fb;
        logic [7:0] n;
        fb = c[0] ^ b;
        n  = c >> 1;
        if (fb) begin
            n = n ^ 8'h8C;
        end
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (crc_clr) begin
            crc <= 8'h00;
        end else if (sample_bit) begin
            crc <= crc8_step(crc, dq_sync2);
        end
    end

    assign crc_out = crc;
`else
    logic unused_crc_clr;
    assign unused_crc_clr = crc_clr;
    assign crc_out        = 8'h00;
`endif

endmodule

// File: doc/onewire_read_byte.md
ONEWIRE_READ_BYTE -- requirements
Module: onewire_read_byte

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz; CYC = CLK_FREQ/1_000_000 clock cycles per microsecond.
REQ-002 SHALL have parameter T_LOW_US, default 6, master low-pulse width in microseconds.
REQ-003 SHALL have parameter T_SAMPLE_US, default 9, delay from bus release to the sample point, in microseconds.
REQ-004 SHALL have parameter T_SLOT_US, default 70, total read-slot length in microseconds.
REQ-005 SHALL have ports: clk  in  1  system clock.
REQ-006 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports: start  in  1  request to read one byte; sampled only when idle.
REQ-008 SHALL have ports: dq_in  in  1  raw 1-Wire bus level (asynchronous).
REQ-009 SHALL have ports: crc_clr  in  1  clears the CRC accumulator.
REQ-010 SHALL have ports: dq_out_en  out  1  1 = drive bus low; 0 = release.
REQ-011 SHALL have ports: busy  out  1  byte read in progress.
REQ-012 SHALL have ports: done  out  1  one-cycle pulse when the byte is complete.
REQ-013 SHALL have ports: data_out  out  8  received byte, LSB first on the wire.
REQ-014 SHALL have ports: crc_out  out  8  running Dallas CRC-8.

Function
REQ-015 SHALL synchronize dq_in through two flip-flops; all sampling SHALL use the synchronized value.
REQ-016 SHALL implement states IDLE, LOW, WAIT_SAMPLE, RECOVER with one shared cycle counter and a 3-bit bit counter.
REQ-017 In IDLE with start=1: next cycle state=LOW, dq_out_en=1, busy=1, bit counter=0, counter=0.
REQ-018 LOW SHALL last T_LOW_US*CYC cycles, then go to WAIT_SAMPLE with dq_out_en=0.
REQ-019 WAIT_SAMPLE SHALL last T_SAMPLE_US*CYC cycles; on its final cycle the synchronized bit SHALL be shifted into data_out[7] with a right shift, so that bit 0 ends in data_out[0].
REQ-020 RECOVER SHALL last (T_SLOT_US-T_LOW_US-T_SAMPLE_US)*CYC cycles with dq_out_en=0.
REQ-021 At the end of RECOVER, if bit counter<7 SHALL increment it and go to LOW; if it is 7 SHALL go to IDLE, clear busy, and pulse done for exactly one cycle.
REQ-022 The byte SHALL take exactly 8*T_SLOT_US*CYC cycles from the first dq_out_en=1 to done.
REQ-023 start while busy=1 SHALL be ignored; start in the cycle done is high is accepted, because the state is already IDLE.
REQ-024 data_out SHALL hold its value after done until the next accepted start; it is not cleared at start.
REQ-025 The slave holding the bus low beyond the sample point SHALL NOT alter timing.

Reset
REQ-026 On rst: state=IDLE, dq_out_en=0, busy=0, done=0, data_out=8'h00, crc_out=8'h00, counters=0, synchronizer=1.
REQ-027 rst asserted mid-slot SHALL release the bus immediately and discard the partial byte.

Configuration
REQ-028 With macro ONEWIRE_READ_CRC8_EN defined: on each sampled bit b, fb=crc[0]^b; crc=crc>>1; if fb then crc^=8'h8C; crc_out=crc.
REQ-029 With ONEWIRE_READ_CRC8_EN defined: crc_clr=1 SHALL zero crc in the next cycle and take priority over a same-cycle bit update.
REQ-030 Without ONEWIRE_READ_CRC8_EN: crc_out SHALL be constant 8'h00, crc_clr SHALL be ignored, and no CRC logic SHALL be synthesized.

Verification
REQ-031 Scenario: CLK_FREQ=100MHz, slave model returns 8'hA5, start pulse -> dq_out_en high 600 cycles per slot, slot 7000 cycles, done at cycle 56000, data_out=8'hA5.
REQ-032 Scenario: slave model holds the line low for whole slots, all bits -> data_out=8'h00; bus released (pull-up) for all bits -> data_out=8'hFF.
REQ-033 Scenario: start asserted at cycle 3000 of slot 2 during a read -> ignored, byte timing unchanged; start in the cycle done=1 -> new read begins the next cycle.
REQ-034 Scenario: rst at cycle 300 of slot 4 -> dq_out_en=0 the same cycle, busy=0, data_out=8'h00; the next start reads a full byte correctly.
REQ-035 Scenario (ONEWIRE_READ_CRC8_EN): crc_clr, then read the 8 ROM bytes 28 FF 4B 46 92 16 03 followed by their CRC byte -> crc_out=8'h00; without the macro, crc_out stays 8'h00 throughout.
